// File: rtl/byte_striping_tx_param.sv
// Round-robin symbol striper: LANES x WIDTH lanes, pad fill, valid mask.
// Optional STRIPE_SEQ_EN adds a 4-bit per-stripe sequence number.
module byte_striping_tx_param #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] PAD = WIDTH'(8'hBC)
) (
  input  logic                     clk,
`ifdef STRIPE_SEQ_EN
  output logic [3:0]               seq_out,
`endif
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     last_in,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     stripe_valid,
  output logic [LANES*WIDTH-1:0]   data_out,
  output logic [LANES-1:0]         lane_mask,
  output logic [$clog2(LANES)-1:0] lane_ptr
);

  localparam int PW = $clog2(LANES);
  localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);

  logic [WIDTH-1:0]       stage_q [LANES];
  logic [WIDTH-1:0]       stage_d [LANES];
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          ptr_d;
  logic                   sv_q;
  logic                   sv_d;
  logic [LANES*WIDTH-1:0] data_q;
  logic [LANES*WIDTH-1:0] data_d;
  logic [LANES-1:0]       mask_q;
  logic [LANES-1:0]       mask_d;
  logic                   accept;
  logic                   complete;

  assign in_ready = !(sv_q && !out_ready);
  assign accept   = valid_in && in_ready;
  assign complete = accept && (last_in || ptr_q == LAST_LANE);

  always_comb begin
    stage_d = stage_q;
    ptr_d   = ptr_q;
    sv_d    = sv_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (out_ready) begin
      sv_d = 1'b0;
    end
    if (complete) begin
      // staged lanes below ptr, live symbol at ptr, pad above
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(ptr_q)) begin
          data_d[i*WIDTH +: WIDTH] = stage_q[i];
          mask_d[i]                = 1'b1;
        end else if (i == int'(ptr_q)) begin
          data_d[i*WIDTH +: WIDTH] = data_in;
          mask_d[i]                = 1'b1;
        end else begin
          data_d[i*WIDTH +: WIDTH] = PAD;
          mask_d[i]                = 1'b0;
        end
        stage_d[i] = '0;
      end
      sv_d  = 1'b1;
      ptr_d = '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (i == int'(ptr_q)) begin
          stage_d[i] = data_in;
        end
      end
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        stage_q[i] <= '0;
      end
      ptr_q  <= '0;
      sv_q   <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      stage_q <= stage_d;
      ptr_q   <= ptr_d;
      sv_q    <= sv_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign stripe_valid = sv_q;
  assign data_out     = data_q;
  assign lane_mask    = mask_q;
  assign lane_ptr     = ptr_q;

`ifdef STRIPE_SEQ_EN
  // cnt_q is the number the next loaded stripe will carry
  logic [3:0] seq_q;
  logic [3:0] seq_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    seq_d = seq_q;
    cnt_d = cnt_q;
    if (complete) begin
      seq_d = cnt_q;
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_q <= '0;
      cnt_q <= '0;
    end else begin
      seq_q <= seq_d;
      cnt_q <= cnt_d;
    end
  end

  assign seq_out = seq_q;
`endif

endmodule

// File: tb/tb_byte_striping_tx_param.sv
// Bench for byte_striping_tx_param: directed scenarios plus a randomized
// run against a queue-based stripe model; second instance is 3x16.
module tb_byte_striping_tx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v4 = 1'b0;
  logic        l4 = 1'b0;
  logic        r4 = 1'b0;
  logic [7:0]  din4 = '0;
  logic        inr4;
  logic        sv4;
  logic [31:0] dout4;
  logic [3:0]  mask4;
  logic [1:0]  ptr4;

  logic        v3 = 1'b0;
  logic        l3 = 1'b0;
  logic        r3 = 1'b1;
  logic [15:0] din3 = '0;
  logic        inr3;
  logic        sv3;
  logic [47:0] dout3;
  logic [2:0]  mask3;
  logic [1:0]  ptr3;

`ifdef STRIPE_SEQ_EN
  logic [3:0] seq4;
  logic [3:0] seq3;
`endif

  byte_striping_tx_param dut4 (
    .clk          (clk),
`ifdef STRIPE_SEQ_EN
    .seq_out      (seq4),
`endif
    .reset        (rst_n),
    .valid_in     (v4),
    .data_in      (din4),
    .last_in      (l4),
    .in_ready     (inr4),
    .out_ready    (r4),
    .stripe_valid (sv4),
    .data_out     (dout4),
    .lane_mask    (mask4),
    .lane_ptr     (ptr4)
  );

  byte_striping_tx_param #(
    .LANES (3),
    .WIDTH (16),
    .PAD   (16'hBCBC)
  ) dut3 (
    .clk          (clk),
`ifdef STRIPE_SEQ_EN
    .seq_out      (seq3),
`endif
    .reset        (rst_n),
    .valid_in     (v3),
    .data_in      (din3),
    .last_in      (l3),
    .in_ready     (inr3),
    .out_ready    (r3),
    .stripe_valid (sv3),
    .data_out     (dout3),
    .lane_mask    (mask3),
    .lane_ptr     (ptr3)
  );

  // reference model for the 4x8 instance
  logic [7:0]  q4 [$];
  logic        m_sv = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_mask = '0;
  logic        exp_inr;
  logic        obs_inr;

  // called just after a falling edge; returns at the next falling edge
  task automatic drv4(input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    logic acc;
    v4 = v; din4 = d; l4 = l; r4 = r;
    #1;
    exp_inr = !(m_sv && !r);
    obs_inr = inr4;
    acc = v && exp_inr;
    @(posedge clk);
    if (!rst_n) begin
      q4.delete();
      m_sv = 1'b0; m_data = '0; m_mask = '0;
    end else begin
      if (acc) q4.push_back(d);
      if (acc && (l || q4.size() == 4)) begin
        for (int i = 0; i < 4; i++) begin
          m_data[i*8 +: 8] = (i < q4.size()) ? q4[i] : 8'hBC;
          m_mask[i] = (i < q4.size());
        end
        q4.delete();
        m_sv = 1'b1;
      end else if (r) begin
        m_sv = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv4(1'b1, 8'h5A, 1'b0, 1'b1);
    drv4(1'b1, 8'h5B, 1'b1, 1'b1);
    checks++;
    if (sv4 !== 1'b0) begin errors++; $display("FAIL rst_sv got %0b exp 0", sv4); end
    checks++;
    if (dout4 !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", dout4); end
    checks++;
    if (mask4 !== 4'h0) begin errors++; $display("FAIL rst_mask got %b exp 0", mask4); end
    checks++;
    if (ptr4 !== 2'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", ptr4); end
    checks++;
    if (sv3 !== 1'b0 || dout3 !== 48'h0 || mask3 !== 3'h0 || ptr3 !== 2'd0) begin
      errors++; $display("FAIL rst_l3 got sv %0b data %h mask %b ptr %0d exp zeros", sv3, dout3, mask3, ptr3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full();
    drv4(1'b1, 8'h11, 1'b0, 1'b1);
    drv4(1'b1, 8'h22, 1'b0, 1'b1);
    drv4(1'b1, 8'h33, 1'b0, 1'b1);
    checks++;
    if (sv4 !== 1'b0 || ptr4 !== 2'd3) begin
      errors++; $display("FAIL full_partial got sv %0b ptr %0d exp sv 0 ptr 3", sv4, ptr4);
    end
    drv4(1'b1, 8'h44, 1'b0, 1'b1);
    checks++;
    if (dout4 !== 32'h44332211) begin errors++; $display("FAIL full_data got %h exp 44332211", dout4); end
    checks++;
    if (mask4 !== 4'hF || sv4 !== 1'b1 || ptr4 !== 2'd0) begin
      errors++; $display("FAIL full_ctl got mask %b sv %0b ptr %0d exp 1111 1 0", mask4, sv4, ptr4);
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (sv4 !== 1'b0 || dout4 !== 32'h44332211) begin
      errors++; $display("FAIL full_drain got sv %0b data %h exp 0 44332211", sv4, dout4);
    end
  endtask

  task automatic test_early_end();
    drv4(1'b1, 8'hAA, 1'b0, 1'b1);
    drv4(1'b1, 8'hBB, 1'b1, 1'b1);
    checks++;
    if (dout4 !== 32'hBCBCBBAA || mask4 !== 4'b0011 || ptr4 !== 2'd0 || sv4 !== 1'b1) begin
      errors++; $display("FAIL early_two got %h mask %b ptr %0d sv %0b exp BCBCBBAA 0011 0 1", dout4, mask4, ptr4, sv4);
    end
    drv4(1'b1, 8'h5A, 1'b1, 1'b1);
    checks++;
    if (dout4 !== 32'hBCBCBC5A || mask4 !== 4'b0001 || sv4 !== 1'b1) begin
      errors++; $display("FAIL early_lane0 got %h mask %b sv %0b exp BCBCBC5A 0001 1", dout4, mask4, sv4);
    end
    drv4(1'b1, 8'h01, 1'b0, 1'b1);
    drv4(1'b1, 8'h02, 1'b0, 1'b1);
    drv4(1'b1, 8'h03, 1'b0, 1'b1);
    drv4(1'b1, 8'h04, 1'b1, 1'b1);
    checks++;
    if (dout4 !== 32'h04030201 || mask4 !== 4'hF || ptr4 !== 2'd0) begin
      errors++; $display("FAIL early_lane3 got %h mask %b ptr %0d exp 04030201 1111 0", dout4, mask4, ptr4);
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    drv4(1'b1, 8'hC1, 1'b0, 1'b0);
    drv4(1'b1, 8'hC2, 1'b0, 1'b0);
    drv4(1'b1, 8'hC3, 1'b0, 1'b0);
    drv4(1'b1, 8'hC4, 1'b0, 1'b0);
    checks++;
    if (sv4 !== 1'b1 || dout4 !== 32'hC4C3C2C1) begin
      errors++; $display("FAIL bp_load got sv %0b data %h exp 1 C4C3C2C1", sv4, dout4);
    end
    for (int k = 0; k < 3; k++) begin
      drv4(1'b1, 8'(k + 8'hE0), 1'b1, 1'b0);
      checks++;
      if (obs_inr !== 1'b0 || ptr4 !== 2'd0 || sv4 !== 1'b1 || dout4 !== 32'hC4C3C2C1 || mask4 !== 4'hF) begin
        errors++; $display("FAIL bp_hold got inr %0b ptr %0d sv %0b data %h mask %b exp 0 0 1 C4C3C2C1 1111", obs_inr, ptr4, sv4, dout4, mask4);
      end
    end
    drv4(1'b1, 8'hD1, 1'b1, 1'b1);
    checks++;
    if (obs_inr !== 1'b1 || sv4 !== 1'b1 || dout4 !== 32'hBCBCBCD1 || mask4 !== 4'b0001) begin
      errors++; $display("FAIL bp_release got inr %0b sv %0b data %h mask %b exp 1 1 BCBCBCD1 0001", obs_inr, sv4, dout4, mask4);
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [8];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      drv4(1'b1, b[i], 1'b0, 1'b1);
      checks++;
      if (obs_inr !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b exp 1", obs_inr); end
      if (i == 3 || i == 7) begin
        checks++;
        if (sv4 !== 1'b1 || dout4 !== {b[i], b[i-1], b[i-2], b[i-3]}) begin
          errors++; $display("FAIL b2b_stripe got sv %0b data %h exp 1 %h", sv4, dout4, {b[i], b[i-1], b[i-2], b[i-3]});
        end
      end
    end
    drv4(1'b1, 8'h71, 1'b1, 1'b1);
    drv4(1'b1, 8'h72, 1'b1, 1'b1);
    checks++;
    if (sv4 !== 1'b1 || dout4 !== 32'hBCBCBC72) begin
      errors++; $display("FAIL b2b_single got sv %0b data %h exp 1 BCBCBC72", sv4, dout4);
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    drv4(1'b1, 8'h01, 1'b0, 1'b1);
    drv4(1'b1, 8'h02, 1'b0, 1'b1);
    rst_n = 1'b0;
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    checks++;
    if (ptr4 !== 2'd0 || sv4 !== 1'b0 || dout4 !== 32'h0) begin
      errors++; $display("FAIL midrst_clear got ptr %0d sv %0b data %h exp 0 0 0", ptr4, sv4, dout4);
    end
    drv4(1'b1, 8'h03, 1'b0, 1'b1);
    drv4(1'b1, 8'h04, 1'b0, 1'b1);
    drv4(1'b1, 8'h05, 1'b0, 1'b1);
    drv4(1'b1, 8'h06, 1'b0, 1'b1);
    checks++;
    if (dout4 !== 32'h06050403 || mask4 !== 4'hF || sv4 !== 1'b1) begin
      errors++; $display("FAIL midrst_stripe got %h mask %b sv %0b exp 06050403 1111 1", dout4, mask4, sv4);
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drv4($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      checks++;
      if (obs_inr !== exp_inr || sv4 !== m_sv || dout4 !== m_data ||
          mask4 !== m_mask || int'(ptr4) != q4.size()) begin
        errors++;
        $display("FAIL rand_%0d got inr %0b sv %0b data %h mask %b ptr %0d exp %0b %0b %h %b %0d",
                 n, obs_inr, sv4, dout4, mask4, ptr4, exp_inr, m_sv, m_data, m_mask, q4.size());
      end
    end
    drv4(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_param3();
    logic [15:0] s [7];
    logic [47:0] exp_d;
    logic [2:0]  exp_m;
    for (int i = 0; i < 7; i++) s[i] = 16'($urandom);
    for (int k = 0; k < 7; k++) begin
      v3 = 1'b1; din3 = s[k]; l3 = (k == 6); r3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (ptr3 !== 2'd1 || sv3 !== 1'b0) begin
          errors++; $display("FAIL p3_first got ptr %0d sv %0b exp 1 0", ptr3, sv3);
        end
      end
      if (k == 2 || k == 5 || k == 6) begin
        if (k == 6) begin
          exp_d = {16'hBCBC, 16'hBCBC, s[6]};
          exp_m = 3'b001;
        end else begin
          exp_d = {s[k], s[k-1], s[k-2]};
          exp_m = 3'b111;
        end
        checks++;
        if (sv3 !== 1'b1 || dout3 !== exp_d || mask3 !== exp_m || ptr3 !== 2'd0) begin
          errors++; $display("FAIL p3_stripe%0d got sv %0b data %h mask %b ptr %0d exp 1 %h %b 0", k, sv3, dout3, mask3, ptr3, exp_d, exp_m);
        end
`ifdef STRIPE_SEQ_EN
        checks++;
        if (seq3 !== 4'((k + 1) / 3 - ((k == 6) ? 0 : 1) + ((k == 6) ? 0 : 0))) begin
          errors++; $display("FAIL p3_seq%0d got %0d exp %0d", k, seq3, (k == 2) ? 0 : (k == 5) ? 1 : 2);
        end
`endif
      end
    end
    v3 = 1'b0; l3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sv3 !== 1'b0 || dout3 !== {16'hBCBC, 16'hBCBC, s[6]}) begin
      errors++; $display("FAIL p3_drain got sv %0b data %h exp 0 %h", sv3, dout3, {16'hBCBC, 16'hBCBC, s[6]});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full();
    test_early_end();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_param3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
